// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache for the fetch stage.
// A hit returns the instruction combinationally in the same cycle. A miss
// raises stall and refills the whole line, one word per beat, from a
// word-wide backing memory.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req, addr        fetch lookup request and byte PC (addr[1:0] ignored)
//   flush            one-cycle pulse that invalidates every line
//   instr, stall     combinational instruction word and fetch stall
//   mem_req/mem_addr registered backing-memory read request and word address
//   mem_rdata/valid  backing-memory read data and its valid strobe
module instr_cache #(
   parameter int unsigned SETS           = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        flush,
   output logic [31:0] instr,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid
);

   localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
   localparam int unsigned LINES_WORDS = SETS * WORDS_PER_LINE;

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t state_q, state_d;

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [LINES_WORDS];

   logic [TAG_W-1:0] fill_tag_q;
   logic [IDX_W-1:0] fill_idx_q;
   logic [OFF_W-1:0] beat_q;
   logic             flush_pending_q;

   logic [OFF_W-1:0] addr_off;
   logic [IDX_W-1:0] addr_idx;
   logic [TAG_W-1:0] addr_tag;
   logic             hit;

   logic start;
   logic accept;
   logic last;
   logic flush_all;

   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   // Address split and lookup
   assign addr_off = addr[2 +: OFF_W];
   assign addr_idx = addr[2 + OFF_W +: IDX_W];
   assign addr_tag = addr[31 -: TAG_W];
   assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
   assign instr    = data_q[{addr_idx, addr_off}];
   assign stall    = (req && !hit) || (state_q != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and refill control strobes
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && !hit && !flush) begin
               start   = 1'b1;
               state_d = REFILL;
            end
         end
         REFILL: begin
            if (mem_req && mem_valid) begin
               accept = 1'b1;
               if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                  last    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A flush in IDLE acts at once; one seen during a refill waits for its end
   assign flush_all = ((state_q == IDLE) && flush) ||
                      (last && (flush || flush_pending_q));

   // Valid bits, beat counter and memory request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q         <= '0;
         beat_q          <= '0;
         mem_req         <= 1'b0;
         mem_addr        <= '0;
         flush_pending_q <= 1'b0;
      end else begin
         if (start) begin
            beat_q   <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {addr_tag, addr_idx, {OFF_W{1'b0}}, 2'b00};
         end
         if (accept) begin
            beat_q   <= beat_q + OFF_W'(1);
            mem_addr <= mem_addr + 32'd4;
            // Partially refilled line must never hit
            if (beat_q == '0) valid_q[fill_idx_q] <= 1'b0;
         end
         if (last) begin
            mem_req             <= 1'b0;
            valid_q[fill_idx_q] <= 1'b1;
            flush_pending_q     <= 1'b0;
         end else if ((state_q == REFILL) && flush) begin
            flush_pending_q <= 1'b1;
         end
         if (flush_all) valid_q <= '0;
      end
   end

   // Tag, data and fill-line registers are not reset
   always_ff @(posedge clk) begin
      if (start) begin
         fill_tag_q <= addr_tag;
         fill_idx_q <= addr_idx;
      end
      if (accept) data_q[{fill_idx_q, beat_q}] <= mem_rdata;
      if (last)   tag_q[fill_idx_q]            <= fill_tag_q;
   end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's per-cycle PC lookups. On a hit it returns the instruction combinationally in the same cycle. On a miss it raises `stall` and runs a line-refill state machine against a word-wide backing instruction memory. It sits between the PC register and the F/D pipeline register, replacing the combinational instruction ROM.

## Interface
Parameters:
- `SETS`, 16: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  fetch presents a valid PC this cycle.
- `addr`  in  32  byte address (PC); `addr[1:0]` ignored.
- `flush`  in  1  one-cycle pulse that invalidates every line (fence.i).
- `instr`  out  32  instruction word; meaningful only when `req && !stall`.
- `stall`  out  1  fetch must hold PC and F/D register this cycle.
- `mem_req`  out  1  backing-memory read request, registered.
- `mem_addr`  out  32  word-aligned read address, registered.
- `mem_rdata`  in  32  backing-memory read data.
- `mem_valid`  in  1  `mem_rdata` valid for the current `mem_addr`; same cycle as `mem_req` or later.

## Operation
- Address split: `[1:0]` byte; next `log2(WORDS_PER_LINE)` bits word offset; next `log2(SETS)` bits index; the remainder is tag (24 bits at default).
- Storage: per-line valid bit and tag in flops; data array `SETS*WORDS_PER_LINE` words, read asynchronously.
- hit = `valid[index] && tag[index] == addr_tag`. `instr` = `data[index][word]`, regardless of hit.
- `stall` = `(req && !hit) || state != IDLE`. This is combinational.
- FSM states:
  - IDLE: if `req && !hit && !flush`, latch line base = `{addr_tag, index, 0...}`. Next state REFILL. Set `mem_req`=1 and `mem_addr`=base; beat=0.
  - REFILL: hold `mem_req`/`mem_addr` until `mem_valid`. On `mem_valid`, write `mem_rdata` to `data[idx][beat]`, beat++, `mem_addr` += 4. On the last beat, clear `mem_req`. Set `tag[idx]`=latched tag and `valid[idx]`=1, unless a flush is pending. Next state IDLE.
- `mem_valid` while `mem_req`=0 is ignored.
- Replacement: the refilled line overwrites the indexed line unconditionally. The line's valid bit is cleared on the first refill beat, so partial data is never hit.
- Flush:
  - In IDLE: all valid bits are cleared at the edge, and no refill starts that cycle.
  - In REFILL: latched in `flush_pending`. The refill completes all beats, so no outstanding memory read is abandoned. At completion, all valid bits are cleared (including the refilled line) and `flush_pending` is cleared.
- `addr` changes during REFILL are ignored. Fetch holds PC while stalled. After returning to IDLE, lookup uses the current `addr`.

## Timing
- Reset values: all valid=0, state=IDLE, beat=0, `mem_req`=0, `mem_addr`=0, `flush_pending`=0. Tags and data are not reset.
- Reset overrides everything, including mid-REFILL. The FSM returns to IDLE, `mem_req` drops at the next edge, and the partial line stays invalid.
- Hit latency: 0 cycles; `instr` is valid in the cycle `addr` is presented.
- Miss detected at cycle t:
  - `mem_req` is high from t+1.
  - With zero-wait memory, beats are accepted at t+1 … t+W, where W = `WORDS_PER_LINE`.
  - The FSM is in IDLE at t+W+1, which is a hit.
  - `stall` is high for cycles t … t+W.
  - Each memory wait cycle adds one stall cycle.
- Only one backing read is outstanding at a time. `mem_addr` advances only on the edge after an accepted beat.
- Word offset wraps within the line: beats are always base, base+4, … base+4(W-1).

## Test plan
- Cold miss:
  - Stimulus: reset, then `req`=1, `addr`=0x0000_0010. Memory is zero-wait and returns `mem_rdata` = `mem_addr ^ 0xA5A5_0000`.
  - Required response: `stall` high for 5 cycles. `mem_addr` sequence is 0x10, 0x14, 0x18, 0x1C. In cycle 5, `stall`=0 and `instr`=0xA5A5_0010.
- Line hit: after the cold miss, step `addr` through 0x14, 0x18, 0x1C. Required: `stall`=0 every cycle, `instr` = 0xA5A5_0014/18/1C, and `mem_req` stays 0.
- Conflict eviction:
  - Stimulus: `addr`=0x0000_0110 (same index 1, different tag), then 0x10.
  - Required response: both addresses miss, giving two full refills. Instructions are 0xA5A5_0110, then 0xA5A5_0010.
- Wait states: memory asserts `mem_valid` 2 cycles after each request. A miss at 0x40 must stall for 1+4×3 = 13 cycles, with `mem_addr` held stable during each wait.
- Flush:
  - Pulse `flush` in IDLE after 0x10 is cached. Required: the next lookup of 0x10 misses.
  - Pulse `flush` mid-refill of 0x20. Required: the refill finishes all 4 beats, then 0x20 misses again.
- Reset mid-refill: assert `rst` during beat 2. Required: `mem_req`=0 on the next cycle, state returns to IDLE, and the old address misses afterward.
